// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the hard-wired zero register and the default counter width.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_FREEZE = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 16;

  // A write to r0 is discarded by the register file, so it can never be a producer.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing bundle of the hazard controller.
// The slave modport is the controller; the master modport is the pipeline that feeds it.
interface hazard_ctrl_if import hazard_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_useRt;
  logic             id_branch;
  logic             id_taken;
  logic [4:0]       ex_rd;
  logic             ex_regWrite;
  logic             ex_memRead;
  logic [4:0]       mem_rd;
  logic             mem_memRead;
  logic             dmem_busy;
  logic             clr_cnt;
  logic             pc_write;
  logic             ifid_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       busy_state;

  modport slave (
    input  id_rs, id_rt, id_useRt, id_branch, id_taken,
    input  ex_rd, ex_regWrite, ex_memRead, mem_rd, mem_memRead,
    input  dmem_busy, clr_cnt,
    output pc_write, ifid_write, exmem_write, memwb_write,
    output ifid_flush, idex_bubble, stall_cycles, flush_count, busy_state
  );

  modport master (
    output id_rs, id_rt, id_useRt, id_branch, id_taken,
    output ex_rd, ex_regWrite, ex_memRead, mem_rd, mem_memRead,
    output dmem_busy, clr_cnt,
    input  pc_write, ifid_write, exmem_write, memwb_write,
    input  ifid_flush, idex_bubble, stall_cycles, flush_count, busy_state
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational bubble-demand decode for the instruction sitting in ID.
// need is the number of bubbles required before the ID instruction may advance.
module hazard_detect import hazard_pkg::*; (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_useRt,
  input  logic       id_branch,
  input  logic [4:0] ex_rd,
  input  logic       ex_regWrite,
  input  logic       ex_memRead,
  input  logic [4:0] mem_rd,
  input  logic       mem_memRead,
  output logic [1:0] need
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_match(ex_rd, id_rs)  || (id_useRt && reg_match(ex_rd, id_rt));
  assign mem_hit = reg_match(mem_rd, id_rs) || (id_useRt && reg_match(mem_rd, id_rt));

  // Branches compare in ID, so an EX load feeding a branch costs an extra
  // cycle over an ordinary load-use; the plain load-use term covers non-branches.
  always_comb begin
    need = 2'd0;
    if (!id_branch && ex_memRead && ex_hit)
      need = 2'd1;
    else if (id_branch && ex_memRead && ex_hit)
      need = 2'd2;
    else if (id_branch && ex_regWrite && !ex_memRead && ex_hit)
      need = 2'd1;
    else if (id_branch && mem_memRead && mem_hit)
      need = 2'd1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/freeze FSM, register-enable decode and
// saturating stall/flush performance counters.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hif
);

  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_STALL  = ST_STALL;
  localparam logic [1:0] S_FREEZE = ST_FREEZE;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_q, saved_d;
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       eff_state;
  logic [1:0]       need;
  logic             stall_req;
  logic [CNT_W-1:0] stall_q, flush_q;

  hazard_detect u_detect (
    .id_rs       (hif.id_rs),
    .id_rt       (hif.id_rt),
    .id_useRt    (hif.id_useRt),
    .id_branch   (hif.id_branch),
    .ex_rd       (hif.ex_rd),
    .ex_regWrite (hif.ex_regWrite),
    .ex_memRead  (hif.ex_memRead),
    .mem_rd      (hif.mem_rd),
    .mem_memRead (hif.mem_memRead),
    .need        (need)
  );

  // Once dmem_busy drops, FREEZE behaves as the interrupted state in that very
  // cycle, so no pipeline cycle is lost on resume.
  assign eff_state = (state_q == S_FREEZE) ? saved_q : state_q;
  assign stall_req = (eff_state == S_STALL) || ((eff_state == S_RUN) && (need != 2'd0));

  always_comb begin
    hif.pc_write    = 1'b1;
    hif.ifid_write  = 1'b1;
    hif.exmem_write = 1'b1;
    hif.memwb_write = 1'b1;
    hif.idex_bubble = 1'b0;
    hif.ifid_flush  = 1'b0;
    if (!reset_n) begin
      hif.pc_write = 1'b1;
    end else if (hif.dmem_busy) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.exmem_write = 1'b0;
      hif.memwb_write = 1'b0;
    end else if (stall_req) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.idex_bubble = 1'b1;
    end else begin
      hif.ifid_flush = hif.id_taken && (eff_state == S_RUN) && (need == 2'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    rem_d   = rem_q;
    if (hif.dmem_busy) begin
      state_d = S_FREEZE;
      saved_d = eff_state;
    end else begin
      case (eff_state)
        S_RUN: begin
          if (need != 2'd0) begin
            rem_d   = need - 2'd1;
            state_d = (need > 2'd1) ? S_STALL : S_RUN;
          end else begin
            state_d = S_RUN;
          end
        end
        S_STALL: begin
          rem_d   = (rem_q != 2'd0) ? rem_q - 2'd1 : 2'd0;
          state_d = (rem_q > 2'd1) ? S_STALL : S_RUN;
        end
        default: begin
          state_d = S_RUN;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      saved_q <= S_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (hif.clr_cnt) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!hif.pc_write && (stall_q != CNT_MAX))
        stall_q <= stall_q + 1'b1;
      if (hif.ifid_flush && (flush_q != CNT_MAX))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign hif.stall_cycles = stall_q;
  assign hif.flush_count  = flush_q;
  assign hif.busy_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the hazard decode in RUN,
// then hand-written sequences for stalls, freeze, flush, saturation and reset.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int W = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  hazard_ctrl_if #(.CNT_W(W)) hif ();

  hazard_ctrl #(.CNT_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hif     (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       branch;
    logic       taken;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_mr;
    logic       exp_pc;
    logic       exp_bub;
    logic       exp_flush;
    logic [1:0] exp_next;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_useRt = 1'b0;
    hif.id_branch = 1'b0; hif.id_taken = 1'b0;
    hif.ex_rd = 5'd0; hif.ex_regWrite = 1'b0; hif.ex_memRead = 1'b0;
    hif.mem_rd = 5'd0; hif.mem_memRead = 1'b0;
    hif.dmem_busy = 1'b0; hif.clr_cnt = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    hif.id_rs = v.rs; hif.id_rt = v.rt; hif.id_useRt = v.use_rt;
    hif.id_branch = v.branch; hif.id_taken = v.taken;
    hif.ex_rd = v.ex_rd; hif.ex_regWrite = v.ex_rw; hif.ex_memRead = v.ex_mr;
    hif.mem_rd = v.mem_rd; hif.mem_memRead = v.mem_mr;
  endtask

  task automatic clear_counters();
    @(negedge clk);
    drive_idle();
    hif.clr_cnt = 1'b1;
    @(negedge clk);
    hif.clr_cnt = 1'b0;
  endtask

  task automatic check_enables(input string nm, input logic pc, input logic bub, input logic fl);
    #1;
    check({nm, ".pc_write"},    hif.pc_write,    pc);
    check({nm, ".ifid_write"},  hif.ifid_write,  pc);
    check({nm, ".idex_bubble"}, hif.idex_bubble, bub);
    check({nm, ".ifid_flush"},  hif.ifid_flush,  fl);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //          name                rs  rt  use br tk exrd rw mr memrd mm  pc bub fl next
    vecs[0]  = '{"load_use_rs",      8,  0,  0, 0, 0,  8,  1, 1,  0,   0,  0, 1,  0, 2'b00};
    vecs[1]  = '{"load_use_rt",      3,  7,  1, 0, 0,  7,  1, 1,  0,   0,  0, 1,  0, 2'b00};
    vecs[2]  = '{"rt_unused",        3,  7,  0, 0, 0,  7,  1, 1,  0,   0,  1, 0,  0, 2'b00};
    vecs[3]  = '{"reg_zero",         0,  0,  0, 0, 0,  0,  1, 1,  0,   0,  1, 0,  0, 2'b00};
    vecs[4]  = '{"br_ex_load",       1,  9,  1, 1, 0,  9,  1, 1,  0,   0,  0, 1,  0, 2'b01};
    vecs[5]  = '{"br_ex_alu",        5,  2,  1, 1, 0,  5,  1, 0,  0,   0,  0, 1,  0, 2'b00};
    vecs[6]  = '{"br_mem_load",      6,  2,  1, 1, 0,  0,  0, 0,  6,   1,  0, 1,  0, 2'b00};
    vecs[7]  = '{"br_taken_nomatch", 4,  2,  1, 1, 1,  5,  1, 0,  0,   0,  1, 0,  1, 2'b00};
    vecs[8]  = '{"taken_stalled",    5,  2,  0, 1, 1,  5,  1, 0,  0,   0,  0, 1,  0, 2'b00};
    vecs[9]  = '{"alu_fwd",          5,  2,  0, 0, 0,  5,  1, 0,  0,   0,  1, 0,  0, 2'b00};
    vecs[10] = '{"mem_load_fwd",     6,  0,  0, 0, 0,  0,  0, 0,  6,   1,  1, 0,  0, 2'b00};
    vecs[11] = '{"br_mem_zero",      0,  0,  0, 1, 0,  0,  0, 0,  0,   1,  1, 0,  0, 2'b00};
    vecs[12] = '{"br_alu_over_mem",  3,  7,  1, 1, 0,  7,  1, 0,  7,   1,  0, 1,  0, 2'b00};
    vecs[13] = '{"br_mem_ex_miss",   6,  0,  0, 1, 0,  4,  1, 1,  6,   1,  0, 1,  0, 2'b00};

    // Reset state
    drive_idle();
    reset_n = 1'b0;
    #2;
    check("rst.state", hif.busy_state, 2'b00);
    check("rst.stall_cycles", hif.stall_cycles, 0);
    check("rst.flush_count", hif.flush_count, 0);
    check("rst.pc_write", hif.pc_write, 1'b1);
    check("rst.memwb_write", hif.memwb_write, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Hazard decode table, each vector applied from a drained RUN state
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      check_enables(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_bub, vecs[i].exp_flush);
      check({vecs[i].name, ".exmem_write"}, hif.exmem_write, 1'b1);
      @(negedge clk);
      #1;
      check({vecs[i].name, ".next_state"}, hif.busy_state, vecs[i].exp_next);
      drive_idle();
      repeat (3) @(negedge clk);
    end

    // Load-use: exactly one bubble
    clear_counters();
    drive_vec(vecs[0]);
    check_enables("lu.c0", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive_idle();
    hif.mem_memRead = 1'b1; hif.mem_rd = 5'd8; hif.id_rs = 5'd8;
    check_enables("lu.c1", 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("lu.stall_cycles", hif.stall_cycles, 1);

    // Branch on EX load: two bubbles through STALL
    clear_counters();
    drive_vec(vecs[4]);
    check_enables("bl.c0", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive_idle();
    hif.id_branch = 1'b1; hif.id_rt = 5'd9; hif.id_useRt = 1'b1;
    hif.mem_memRead = 1'b1; hif.mem_rd = 5'd9;
    check_enables("bl.c1", 1'b0, 1'b1, 1'b0);
    check("bl.c1.state", hif.busy_state, 2'b01);
    @(negedge clk);
    drive_idle();
    check_enables("bl.c2", 1'b1, 1'b0, 1'b0);
    check("bl.c2.state", hif.busy_state, 2'b00);
    check("bl.stall_cycles", hif.stall_cycles, 2);

    // Freeze for three cycles in the middle of a STALL
    clear_counters();
    drive_vec(vecs[4]);
    @(negedge clk);
    drive_idle();
    hif.id_branch = 1'b1; hif.id_rt = 5'd9; hif.id_useRt = 1'b1;
    hif.mem_memRead = 1'b1; hif.mem_rd = 5'd9;
    hif.dmem_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_enables($sformatf("fz.c%0d", c), 1'b0, 1'b0, 1'b0);
      check($sformatf("fz.c%0d.exmem_write", c), hif.exmem_write, 1'b0);
      check($sformatf("fz.c%0d.memwb_write", c), hif.memwb_write, 1'b0);
      check($sformatf("fz.c%0d.state", c), hif.busy_state, (c == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
    end
    hif.dmem_busy = 1'b0;
    check_enables("fz.resume", 1'b0, 1'b1, 1'b0);
    check("fz.resume.exmem_write", hif.exmem_write, 1'b1);
    @(negedge clk);
    drive_idle();
    check_enables("fz.after", 1'b1, 1'b0, 1'b0);
    check("fz.after.state", hif.busy_state, 2'b00);
    check("fz.stall_cycles", hif.stall_cycles, 5);

    // Taken branch with no hazard flushes once
    clear_counters();
    hif.id_branch = 1'b1; hif.id_taken = 1'b1; hif.id_rs = 5'd4;
    check_enables("tk.c0", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive_idle();
    check_enables("tk.c1", 1'b1, 1'b0, 1'b0);
    check("tk.flush_count", hif.flush_count, 1);

    // Taken branch behind an ALU hazard flushes only after its stall
    clear_counters();
    drive_vec(vecs[8]);
    check_enables("tks.c0", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    hif.ex_rd = 5'd0; hif.ex_regWrite = 1'b0;
    check_enables("tks.c1", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive_idle();
    #1;
    check("tks.flush_count", hif.flush_count, 1);
    check("tks.stall_cycles", hif.stall_cycles, 1);

    // Saturation at all-ones, then clear beats increment
    clear_counters();
    drive_vec(vecs[0]);
    repeat (20) @(negedge clk);
    #1;
    check("sat.stall_cycles", hif.stall_cycles, 15);
    hif.clr_cnt = 1'b1;
    @(negedge clk);
    #1;
    check("sat.clr_priority", hif.stall_cycles, 0);
    drive_idle();
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a STALL
    drive_vec(vecs[4]);
    @(negedge clk);
    #1;
    check("rs.pre.state", hif.busy_state, 2'b01);
    check("rs.pre.stall_cycles", hif.stall_cycles, 1);
    reset_n = 1'b0;
    #1;
    check("rs.state", hif.busy_state, 2'b00);
    check("rs.stall_cycles", hif.stall_cycles, 0);
    check("rs.pc_write", hif.pc_write, 1'b1);
    check("rs.idex_bubble", hif.idex_bubble, 1'b0);
    @(negedge clk);
    drive_idle();
    reset_n = 1'b1;
    check_enables("rs.after", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rs.after.state", hif.busy_state, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
